// File: rtl/ripple_cnt_monitor.sv
// ripple_cnt_monitor
//   Samples the Q outputs of an asynchronous ripple up counter in the clk
//   domain. It waits for the sampled value to settle, then accepts it. It
//   tracks the accepted value and flags terminal-count hits, wraps and
//   non-unit steps.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cnt_in     ripple counter Q outputs (asynchronous to clk), bit 0 = LSB
//   clear      synchronous clear of the monitor state
//   tc_value   terminal count to match (quasi-static)
//   count_out  last accepted (stable) counter value
//   valid      count_out holds an accepted value
//   tc_hit     one-cycle pulse when the accepted value becomes tc_value
//   wrap       one-cycle pulse when the accepted value wraps (new < old)
//   wrap_count number of wraps, saturating at 255
//   skip_err   sticky flag: an accepted step was not +1 modulo 2^WIDTH
module ripple_cnt_monitor #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clear,
  input  logic [WIDTH-1:0] tc_value,
  output logic [WIDTH-1:0] count_out,
  output logic             valid,
  output logic             tc_hit,
  output logic             wrap,
  output logic [7:0]       wrap_count,
  output logic             skip_err
);

  localparam int unsigned STAB_W  = 4;
  localparam int unsigned PRIME_W = 2;
  localparam logic [STAB_W-1:0]  STAB_MAX    = STAB_W'(SETTLE - 1);
  localparam logic [PRIME_W-1:0] PRIME_FULL  = PRIME_W'(3);
  localparam logic [PRIME_W-1:0] PRIME_CLEAR = PRIME_W'(2);

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     s1;
  logic [WIDTH-1:0]     s2;
  logic [WIDTH-1:0]     s2_prev;
  logic [STAB_W-1:0]    stab;
  logic [PRIME_W-1:0]   prime_cnt;

  logic                 s_eq_c;
  logic                 primed_c;
  logic                 commit_c;
  logic [WIDTH-1:0]     next_exp_c;

  // Stability tracking only counts once s2 and s2_prev both hold values
  // sampled from cnt_in, so the reset contents are never accepted.
  assign s_eq_c     = (s2 == s2_prev);
  assign primed_c   = (prime_cnt == PRIME_FULL);
  assign commit_c   = primed_c && s_eq_c && (stab == STAB_MAX) &&
                      ((s2 != count_out) || (state == EMPTY));
  assign next_exp_c = count_out + WIDTH'(1);

  // Two-stage synchronizer plus previous-sample register; unaffected by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      s2_prev <= '0;
    end else begin
      s1      <= cnt_in;
      s2      <= s1;
      s2_prev <= s2;
    end
  end

  // Priming counter: reaches full once the synchronizer pipe holds real
  // samples. A clear drops it back one step so a pending value needs one
  // extra stable edge before it is re-accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_cnt <= '0;
    end else if (clear && primed_c) begin
      prime_cnt <= PRIME_CLEAR;
    end else if (!primed_c) begin
      prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

  // Stability counter, saturating at SETTLE-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stab <= '0;
    end else if (clear || !primed_c || !s_eq_c) begin
      stab <= '0;
    end else if (stab != STAB_MAX) begin
      stab <= stab + STAB_W'(1);
    end
  end

  // Monitor FSM with registered outputs; clear wins over a same-edge commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      count_out  <= '0;
      valid      <= 1'b0;
      tc_hit     <= 1'b0;
      wrap       <= 1'b0;
      wrap_count <= '0;
      skip_err   <= 1'b0;
    end else begin
      tc_hit <= 1'b0;
      wrap   <= 1'b0;
      if (clear) begin
        state      <= EMPTY;
        count_out  <= '0;
        valid      <= 1'b0;
        wrap_count <= '0;
        skip_err   <= 1'b0;
      end else if (commit_c) begin
        count_out <= s2;
        tc_hit    <= (s2 == tc_value);
        case (state)
          EMPTY: begin
            // First accepted value is only a baseline.
            state <= TRACK;
            valid <= 1'b1;
          end
          TRACK: begin
            if (s2 < count_out) begin
              wrap <= 1'b1;
              if (wrap_count != 8'hFF) begin
                wrap_count <= wrap_count + 8'd1;
              end
            end
            if (s2 != next_exp_c) begin
              skip_err <= 1'b1;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ripple_cnt_monitor.sv
// tb_ripple_cnt_monitor
//   Directed bench for ripple_cnt_monitor (WIDTH=4, SETTLE=2). Each task
//   drives one scenario and compares outputs against hand-computed values.
module tb_ripple_cnt_monitor;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SETTLE = 2;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] cnt_in;
  logic             clear;
  logic [WIDTH-1:0] tc_value;
  logic [WIDTH-1:0] count_out;
  logic             valid;
  logic             tc_hit;
  logic             wrap;
  logic [7:0]       wrap_count;
  logic             skip_err;

  int checks;
  int errors;

  ripple_cnt_monitor #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .clear      (clear),
    .tc_value   (tc_value),
    .count_out  (count_out),
    .valid      (valid),
    .tc_hit     (tc_hit),
    .wrap       (wrap),
    .wrap_count (wrap_count),
    .skip_err   (skip_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with cnt_in already at v; the next rising edge after return is edge 1.
  task automatic do_reset(input logic [WIDTH-1:0] v);
    #2;
    reset  = 1'b1;
    cnt_in = v;
    clear  = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (count_out !== 4'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_count: count_out=%0d valid=%0b, required 0/0", count_out, valid);
    end
    checks++;
    if (tc_hit !== 1'b0 || wrap !== 1'b0 || wrap_count !== 8'd0 || skip_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: tc_hit=%0b wrap=%0b wrap_count=%0d skip_err=%0b, required all 0",
               tc_hit, wrap, wrap_count, skip_err);
    end
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_first_commit;
    tc_value = 4'd9;
    do_reset(4'd3);
    tick(4);
    checks++;
    if (valid !== 1'b0 || count_out !== 4'd0) begin
      errors++;
      $display("FAIL first_commit_edge4: count_out=%0d valid=%0b, required 0/0", count_out, valid);
    end
    tick(1);
    checks++;
    if (count_out !== 4'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL first_commit_edge5: count_out=%0d valid=%0b, required 3/1", count_out, valid);
    end
    checks++;
    if (tc_hit !== 1'b0 || wrap !== 1'b0 || skip_err !== 1'b0) begin
      errors++;
      $display("FAIL first_commit_flags: tc_hit=%0b wrap=%0b skip_err=%0b, required 0/0/0",
               tc_hit, wrap, skip_err);
    end
  endtask

  task automatic test_count_sequence;
    int wraps_seen;
    int tcs_seen;
    int bad_wrap_val;
    int follow_err;
    logic [WIDTH-1:0] v;
    wraps_seen   = 0;
    tcs_seen     = 0;
    bad_wrap_val = 0;
    follow_err   = 0;
    tc_value = 4'd9;
    do_reset(4'd0);
    tick(10);
    checks++;
    if (count_out !== 4'd0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_start: count_out=%0d valid=%0b, required 0/1", count_out, valid);
    end
    for (int i = 1; i <= 16; i++) begin
      v = WIDTH'(i % 16);
      cnt_in = v;
      for (int k = 0; k < 10; k++) begin
        tick(1);
        if (wrap === 1'b1) begin
          wraps_seen++;
          if (count_out !== 4'd0) bad_wrap_val++;
        end
        if (tc_hit === 1'b1) tcs_seen++;
      end
      if (count_out !== v) begin
        follow_err++;
        $display("FAIL seq_follow: count_out=%0d, required %0d", count_out, v);
      end
    end
    checks++;
    if (follow_err !== 0) begin
      errors++;
      $display("FAIL seq_follow_total: %0d values not followed, required 0", follow_err);
    end
    checks++;
    if (wraps_seen !== 1 || bad_wrap_val !== 0) begin
      errors++;
      $display("FAIL seq_wrap_pulse: pulses=%0d misaligned=%0d, required 1/0", wraps_seen, bad_wrap_val);
    end
    checks++;
    if (wrap_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_wrap_count: wrap_count=%0d, required 1", wrap_count);
    end
    checks++;
    if (skip_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_skip_err: skip_err=%0b, required 0", skip_err);
    end
    checks++;
    if (tcs_seen !== 1) begin
      errors++;
      $display("FAIL seq_tc_hit: pulses=%0d, required 1", tcs_seen);
    end
  endtask

  task automatic test_glitch;
    int saw6;
    saw6 = 0;
    do_reset(4'd7);
    tick(10);
    cnt_in = 4'd6;
    tick(1);
    cnt_in = 4'd8;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (count_out === 4'd6) saw6++;
    end
    checks++;
    if (saw6 !== 0) begin
      errors++;
      $display("FAIL glitch_discard: cycles with count_out=6 is %0d, required 0", saw6);
    end
    checks++;
    if (count_out !== 4'd8 || skip_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_accept: count_out=%0d skip_err=%0b, required 8/0", count_out, skip_err);
    end
  endtask

  task automatic test_skip;
    do_reset(4'd4);
    tick(10);
    cnt_in = 4'd6;
    tick(10);
    checks++;
    if (count_out !== 4'd6 || skip_err !== 1'b1) begin
      errors++;
      $display("FAIL skip_set: count_out=%0d skip_err=%0b, required 6/1", count_out, skip_err);
    end
    cnt_in = 4'd7;
    tick(10);
    checks++;
    if (count_out !== 4'd7 || skip_err !== 1'b1) begin
      errors++;
      $display("FAIL skip_sticky: count_out=%0d skip_err=%0b, required 7/1", count_out, skip_err);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++;
    if (skip_err !== 1'b0 || valid !== 1'b0 || count_out !== 4'd0) begin
      errors++;
      $display("FAIL skip_clear: skip_err=%0b valid=%0b count_out=%0d, required 0/0/0",
               skip_err, valid, count_out);
    end
    tick(10);
    checks++;
    if (count_out !== 4'd7 || valid !== 1'b1 || skip_err !== 1'b0) begin
      errors++;
      $display("FAIL skip_rebase: count_out=%0d valid=%0b skip_err=%0b, required 7/1/0",
               count_out, valid, skip_err);
    end
  endtask

  task automatic test_tc;
    int tcs_seen;
    int misaligned;
    tcs_seen   = 0;
    misaligned = 0;
    tc_value = 4'd12;
    do_reset(4'd10);
    tick(10);
    for (int v = 11; v <= 13; v++) begin
      cnt_in = WIDTH'(v);
      for (int k = 0; k < 10; k++) begin
        tick(1);
        if (tc_hit === 1'b1) begin
          tcs_seen++;
          if (count_out !== 4'd12) misaligned++;
        end
      end
    end
    checks++;
    if (tcs_seen !== 1) begin
      errors++;
      $display("FAIL tc_single: tc_hit cycles=%0d, required 1", tcs_seen);
    end
    checks++;
    if (misaligned !== 0) begin
      errors++;
      $display("FAIL tc_align: cycles with tc_hit and count_out!=12 is %0d, required 0", misaligned);
    end
  endtask

  task automatic test_clear_commit;
    tc_value = 4'd9;
    do_reset(4'd4);
    tick(10);
    cnt_in = 4'd5;
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++;
    if (count_out !== 4'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: count_out=%0d valid=%0b, required 0/0", count_out, valid);
    end
    tick(2);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold: valid=%0b two edges after clear, required 0", valid);
    end
    tick(1);
    checks++;
    if (count_out !== 4'd5 || valid !== 1'b1 || skip_err !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clear_reaccept: count_out=%0d valid=%0b skip_err=%0b wrap=%0b, required 5/1/0/0",
               count_out, valid, skip_err, wrap);
    end
  endtask

  task automatic test_wrap_saturate;
    do_reset(4'd0);
    tick(7);
    for (int i = 0; i < 300; i++) begin
      cnt_in = 4'd15;
      tick(7);
      cnt_in = 4'd0;
      tick(7);
      if (i == 99) begin
        checks++;
        if (wrap_count !== 8'd100) begin
          errors++;
          $display("FAIL wrap_count_100: wrap_count=%0d, required 100", wrap_count);
        end
      end
    end
    checks++;
    if (wrap_count !== 8'd255) begin
      errors++;
      $display("FAIL wrap_count_sat: wrap_count=%0d, required 255", wrap_count);
    end
  endtask

  task automatic test_reset_midcommit;
    tc_value = 4'd10;
    do_reset(4'd9);
    tick(10);
    cnt_in = 4'd10;
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count_out !== 4'd0 || valid !== 1'b0 || wrap_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: count_out=%0d valid=%0b wrap_count=%0d, required 0/0/0",
               count_out, valid, wrap_count);
    end
    tick(2);
    reset = 1'b0;
    tick(4);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart_edge4: valid=%0b, required 0", valid);
    end
    tick(1);
    checks++;
    if (count_out !== 4'd10 || valid !== 1'b1 || tc_hit !== 1'b1 || skip_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart_edge5: count_out=%0d valid=%0b tc_hit=%0b skip_err=%0b, required 10/1/1/0",
               count_out, valid, tc_hit, skip_err);
    end
    tick(1);
    checks++;
    if (tc_hit !== 1'b0) begin
      errors++;
      $display("FAIL tc_pulse_width: tc_hit=%0b one edge later, required 0", tc_hit);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    clear    = 1'b0;
    cnt_in   = '0;
    tc_value = 4'd9;
    test_reset();
    test_first_commit();
    test_count_sequence();
    test_glitch();
    test_skip();
    test_tc();
    test_clear_commit();
    test_wrap_saturate();
    test_reset_midcommit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
